perf_stats: RTL

PERF_STATS -- requirements
Module: perf_stats

---
 rtl/perf_stats.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/perf_stats.sv
// Performance statistics block: cycle, retired-instruction and generic event counters,
// with snapshot capture and a serial restoring divider producing fixed-point IPC.
module perf_stats #(
    parameter int CNT_W    = 32,
    parameter int NUM_EV   = 4,
    parameter int FRAC_W   = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          count_en,
    input  logic                          clear,
    input  logic                          retire,
    input  logic [NUM_EV-1:0]             event_in,
    input  logic                          snap_req,
    input  logic [$clog2(NUM_EV+2)-1:0]   rd_sel,
    output logic [CNT_W-1:0]              rd_data,
    output logic                          snap_busy,
    output logic                          snap_done,
    output logic [CNT_W+FRAC_W-1:0]       ipc_q,
    output logic                          div_zero,
    output logic [NUM_EV+1:0]             ovf
);

    localparam int NCH   = NUM_EV + 2;
    localparam int SEL_W = $clog2(NCH);
    localparam int QW    = CNT_W + FRAC_W;
    localparam int BC_W  = $clog2(QW + 1);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    state_t state, nextState;

    // Channel layout everywhere: 0 = cycles, 1 = instructions, 2+k = event k
    logic [CNT_W-1:0] liveCnt [NCH];
    logic [CNT_W-1:0] snapCnt [NCH];
    logic [NCH-1:0]   incVec;

    logic [CNT_W-1:0] remR;
    logic [QW-1:0]    quoR;
    logic [CNT_W-1:0] divisorR;
    logic [BC_W-1:0]  bitCnt;
    logic             divZeroR;

    logic [CNT_W:0]   trial;
    logic             qBit;
    logic [CNT_W-1:0] remNext;
    logic [QW-1:0]    quoNext;
    logic             lastStep;

    function automatic logic [CNT_W-1:0] bumpCount(input logic [CNT_W-1:0] cnt);
        if (cnt == '1) begin
            return SATURATE ? '1 : '0;
        end
        return cnt + CNT_W'(1);
    endfunction

    assign incVec = count_en ? {event_in, retire, 1'b1} : '0;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            for (int i = 0; i < NCH; i++) begin
                liveCnt[i] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (incVec[i]) begin
                    liveCnt[i] <= bumpCount(liveCnt[i]);
                    if (liveCnt[i] == '1) begin
                        ovf[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        trial   = {remR, quoR[QW-1]};
        qBit    = (trial >= {1'b0, divisorR});
        remNext = qBit ? (trial[CNT_W-1:0] - divisorR) : trial[CNT_W-1:0];
        quoNext = {quoR[QW-2:0], qBit};
    end

    assign lastStep = (bitCnt == BC_W'(QW - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        snap_busy = 1'b0;
        snap_done = 1'b0;
        case (state)
            IDLE: begin
                if (snap_req) begin
                    nextState = DIV;
                end
            end
            DIV: begin
                snap_busy = 1'b1;
                if (lastStep) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                snap_done = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Snapshot capture and divider datapath; results land as DONE is entered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                snapCnt[i] <= '0;
            end
            remR     <= '0;
            quoR     <= '0;
            divisorR <= '0;
            bitCnt   <= '0;
            divZeroR <= 1'b0;
            ipc_q    <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (snap_req) begin
                        for (int i = 0; i < NCH; i++) begin
                            snapCnt[i] <= liveCnt[i];
                        end
                        remR     <= '0;
                        quoR     <= {liveCnt[1], {FRAC_W{1'b0}}};
                        divisorR <= liveCnt[0];
                        bitCnt   <= '0;
                        divZeroR <= (liveCnt[0] == '0);
                    end
                end
                DIV: begin
                    remR   <= remNext;
                    quoR   <= quoNext;
                    bitCnt <= bitCnt + BC_W'(1);
                    if (lastStep) begin
                        ipc_q    <= divZeroR ? '1 : quoNext;
                        div_zero <= divZeroR;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_data = snapCnt[i];
            end
        end
    end

endmodule
